shared_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit storage register, built from D flip-flops, between NREQ requesters. Each granted requester does one access: a write of its data, or a read. The arbiter sequences each access through a fixed 3-state FSM and returns the register contents with a valid strobe. It sits between the requesting control blocks and the shared flip-flop register.

---
 rtl/shared_reg_arbiter_pkg.sv | 31 +++
 rtl/shared_reg_arbiter_dff_reg.sv | 20 ++
 rtl/shared_reg_arbiter.sv | 132 +++++++++++++
 tb/tb_shared_reg_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and the round-robin winner search for shared_reg_arbiter.
package shared_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int STATE_W = 2;
    localparam int MAX_REQ = 8;

    // First set request bit scanning ptr, ptr+1, ... modulo nreq; 0 when req is empty.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input int nreq);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (i < nreq && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_dff_reg.sv
// WIDTH-bit D flip-flop bank with synchronous active-low clear and load enable.
module dff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one read/write access at a time to a shared register.
// Optional back-to-back locked accesses are enabled with `define SHARED_REG_LOCK_EN.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    input  logic [NREQ-1:0]         lock,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    rvalid,
    output logic [WIDTH-1:0]        rdata,
    output state_t                  fsm_state
);

    localparam int OW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic            op_wr_q;
    logic [WIDTH-1:0] op_data_q;
    logic [7:0]      req_ext;
    logic [2:0]      ptr_ext;
    logic [2:0]      winner;
    logic            reg_en;
    logic            winner_unused;

`ifdef SHARED_REG_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
`else
    logic lock_unused;
    assign lock_unused = ^lock;
`endif

    always_comb begin
        req_ext              = '0;
        req_ext[NREQ-1:0]    = req;
        ptr_ext              = '0;
        ptr_ext[OW-1:0]      = ptr_q;
    end

    assign winner        = rr_pick(req_ext, ptr_ext, NREQ);
    assign winner_unused = ^winner;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt     = '0;
        rvalid  = 1'b0;
        reg_en  = 1'b0;
`ifdef SHARED_REG_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = winner[OW-1:0];
                    state_d = ACCESS;
`ifdef SHARED_REG_LOCK_EN
                    lock_cnt_d = '0;
`endif
                end
            end
            ACCESS: begin
                gnt[owner_q] = 1'b1;
                reg_en       = op_wr_q;
                state_d      = DONE;
            end
            DONE: begin
                rvalid  = 1'b1;
                ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
`ifdef SHARED_REG_LOCK_EN
                // The first access counts toward LOCK_MAX, so at most LOCK_MAX in a row.
                if (lock[owner_q] && req[owner_q] && (int'(lock_cnt_q) + 1 < LOCK_MAX)) begin
                    state_d    = ACCESS;
                    ptr_d      = ptr_q;
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Op and data are captured on entry to ACCESS so a requester may let go mid-access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            op_wr_q   <= 1'b0;
            op_data_q <= '0;
`ifdef SHARED_REG_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            if (state_d == ACCESS) begin
                op_wr_q   <= wr[owner_d];
                op_data_q <= wdata[owner_d*WIDTH +: WIDTH];
            end
`ifdef SHARED_REG_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    dff_reg #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (reg_en),
        .d   (op_data_q),
        .q   (rdata)
    );

    assign owner     = owner_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed scoreboard bench for shared_reg_arbiter (NREQ=4, WIDTH=8).
module tb_shared_reg_arbiter;
    import shared_reg_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int SB_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   wr = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [NREQ-1:0]   gnt;
    logic [1:0]        owner;
    logic              rvalid;
    logic [WIDTH-1:0]  rdata;
    state_t            fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [WIDTH-1:0] model_reg = '0;
    logic [SB_W-1:0] exp_q[$];

    shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .wdata     (wdata),
        .lock      (lock),
        .gnt       (gnt),
        .owner     (owner),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .fsm_state (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (gnt != '0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got no grant expected a grant at cycle %0d", cyc);
        end
    endtask

    // One complete access by requester idx; drop_early releases req/wr inside ACCESS.
    task automatic run_access(input int idx, input logic w, input logic [7:0] d,
                              input logic drop_early);
        logic ok;
        @(posedge clk); #1;
        req[idx] = 1'b1;
        wr[idx]  = w;
        wdata[idx*WIDTH +: WIDTH] = d;
        if (w) model_reg = d;
        exp_q.push_back({2'(idx), model_reg});
        wait_gnt(ok);
        if (ok) check("gnt_value", 32'(gnt), 32'(1) << idx);
        if (drop_early) begin
            req[idx] = 1'b0;
            wr[idx]  = 1'b0;
        end
        @(posedge clk); #1;
        req[idx] = 1'b0;
        wr[idx]  = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [SB_W-1:0] e;
        if (mon_en) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("gnt_rvalid_excl", 32'((gnt != '0) && rvalid), 32'd0);
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected: got rvalid with rdata %0h expected no rvalid", rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", 32'(rdata), 32'(e[7:0]));
                    check("owner", 32'(owner), 32'(e[9:8]));
                end
            end
        end
    end

    initial begin
        logic ok;
        int last;
        int n;
        int exp_own[5];

        // Reset held for two edges with every requester asking
        req = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // Single write then read
        run_access(2, 1'b1, 8'hA5, 1'b0);
        run_access(0, 1'b0, 8'h00, 1'b0);
        check("read_keeps_reg", 32'(rdata), 32'hA5);

        // Withdrawal during ACCESS still commits
        run_access(1, 1'b1, 8'h3C, 1'b1);

        // Reset in the ACCESS cycle aborts a pending write
        run_access(2, 1'b1, 8'h55, 1'b0);
        check("reg_55", 32'(rdata), 32'h55);
        @(posedge clk); #1;
        req[1] = 1'b1;
        wr[1]  = 1'b1;
        wdata[1*WIDTH +: WIDTH] = 8'hFF;
        wait_gnt(ok);
        rst = 1'b0;
        @(posedge clk); #1;
        req = '0;
        wr  = '0;
        model_reg = '0;
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_rvalid", 32'(rvalid), 32'd0);
        check("abort_rdata", 32'(rdata), 32'h00);
        check("abort_owner", 32'(owner), 32'd0);
        check("abort_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Round robin from ptr=0 with all requesters held
        @(posedge clk); #1;
        req = 4'b1111;
        wr  = '0;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(ok);
            exp_q.push_back({2'(k % 4), model_reg});
            if (ok) begin
                check("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
                if (k > 0) check("rr_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
            end
        end
        @(posedge clk); #1;
        req = '0;
        repeat (3) @(negedge clk);

        // Lock request from requester 3 against requester 0 (ptr=1 here)
`ifdef SHARED_REG_LOCK_EN
        n = 5;
        exp_own = '{3, 3, 3, 3, 0};
`else
        n = 4;
        exp_own = '{3, 0, 3, 0, 0};
`endif
        @(posedge clk); #1;
        req  = 4'b1001;
        lock = 4'b1000;
        for (int k = 0; k < n; k++) begin
            wait_gnt(ok);
            exp_q.push_back({2'(exp_own[k]), model_reg});
            if (ok) check("lock_gnt", 32'(gnt), 32'(1) << exp_own[k]);
        end
        @(posedge clk); #1;
        req  = '0;
        lock = '0;

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
